bp_table_ctrl: RTL
==================

// Module: bp_table_ctrl
// PURPOSE
//  Owns and sequences a table of 2-bit saturating branch counters behind one single-port array.
//  Arbitrates each cycle between fetch-stage prediction reads, queued execute-stage updates and
//  a table-initialise walk (after reset or flush). Sits between IF (predict) and EX (resolve).
// PARAMETERS
//  IDX_W    4  table index width; table has 2**IDX_W entries
//  Q_DEPTH  2  update queue depth, >=1
// PORTS
//  clk           in   1      clock
//  rst           in   1      asynchronous, active-high reset
//  pred_valid    in   1      IF requests a prediction
//  pred_idx      in   IDX_W  table index for the prediction
//  pred_ready    out  1      prediction request accepted this cycle
//  pred_out_vld  out  1      registered; prediction result valid
//  pred_taken    out  1      registered; predicted direction (counter MSB)
//  upd_valid     in   1      EX presents a resolved branch
//  upd_idx       in   IDX_W  table index of the resolved branch
//  upd_actual    in   1      1 = branch taken
//  upd_ready     out  1      update accepted this cycle
//  flush         in   1      synchronous request to reinitialise the table
//  busy          out  1      high while INIT walk in progress
// BEHAVIOUR
//  Reset (async, rst=1): state=INIT, init_ptr=0, queue empty (count=0),
//   pred_out_vld=0, pred_taken=0, busy=1. Table contents are not reset directly; INIT rewrites them.
//  FSM states:
//   INIT: each cycle writes 2'b01 (weak not-taken) to table[init_ptr], then init_ptr++.
//         After the cycle that writes entry 2**IDX_W-1, next state is RUN.
//   RUN:  normal operation. flush=1 in RUN -> INIT next cycle, init_ptr=0, queue emptied.
//         Queued updates are dropped.
//   flush=1 in INIT restarts the walk: init_ptr=0.
//   busy = (state==INIT); a full walk takes exactly 2**IDX_W cycles.
//  Handshakes, all combinational from registered state:
//   pred_ready = RUN && count!=Q_DEPTH
//   upd_ready  = RUN && count!=Q_DEPTH
//   In INIT, both are 0.
//  Single array op per cycle. Priority: INIT write > drain-if-full > accepted prediction >
//   drain-if-nonempty.
//  Prediction: accepted at cycle t -> pred_out_vld=1 at t+1, pred_taken=table[pred_idx][1]
//   as read at t. pred_out_vld=0 in any cycle after a non-accepted one; pred_taken holds.
//  Update enqueue: upd_valid&&upd_ready at t -> entry {idx,actual} at tail. Simultaneous
//   enqueue+drain allowed; count net unchanged. FIFO order preserved.
//  Drain: head entry applied to table[idx] with a 2-bit saturating step:
//   actual=1: 00->01->10->11, 11 stays 11.
//   actual=0: 11->10->01->00, 00 stays 00.
//   The write is visible to predictions accepted from the next cycle onward.
//  No bypass: a prediction of an index with a pending queued update returns the stale value.
//  flush takes effect even if pred/upd handshakes complete in the same cycle. Those transactions
//   are discarded, but pred_out_vld still pulses at t+1 for an accepted prediction.
//  rst asserted mid-walk or mid-queue returns immediately to the reset values above.
// TESTING
//  1 Reset, then idle -> busy=1 for 16 cycles, 0 after.
//    pred idx 3 -> pred_out_vld next cycle, pred_taken=0.
//  2 Two updates idx5 actual=1, idle 2 cycles, predict idx5 -> pred_taken=1 (01->10->11).
//  3 Four taken then one not-taken to idx9 -> predict 1. Two more not-taken -> predict 0.
//  4 pred_valid held high every cycle, push 2 updates -> count reaches 2, pred_ready=0 one
//    cycle (forced drain), then 1 and drains resume when pred_valid drops.
//  5 Two queued updates to idx5 then flush -> upd_ready/pred_ready=0, busy 16 cycles,
//    idx5 predicts 0.
//  6 rst pulse while init_ptr=7 -> outputs reset asynchronously, walk restarts at 0,
//    busy 16 more cycles.

Source files
------------

// File: rtl/bp_table_ctrl_if.sv
// rtl/bp_table_ctrl_if.sv - predict/update/flush bundle between IF/EX and the branch table
interface bp_table_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;
  logic             pred_out_vld;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_actual;
  logic             upd_ready;
  logic             flush;
  logic             busy;

  modport master (
    output pred_valid, pred_idx, upd_valid, upd_idx, upd_actual, flush,
    input  pred_ready, pred_out_vld, pred_taken, upd_ready, busy
  );

  modport slave (
    input  pred_valid, pred_idx, upd_valid, upd_idx, upd_actual, flush,
    output pred_ready, pred_out_vld, pred_taken, upd_ready, busy
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// rtl/bp_table_ctrl.sv - 2-bit saturating branch counter table on one single-port array
module bp_table_ctrl #(
  parameter int IDX_W   = 4,
  parameter int Q_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  bp_table_ctrl_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PTR_W   = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W   = $clog2(Q_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Q_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Q_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_ptr;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             pred_out_vld, pred_taken;

  logic [1:0]       table_mem [ENTRIES];
  logic [IDX_W-1:0] q_idx     [Q_DEPTH];
  logic             q_act     [Q_DEPTH];

  logic             busy, ready, full, pred_acc, upd_acc, drain, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       mem_wdata;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // One array op per cycle: init write, then forced drain, then prediction read, then drain.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    full      = (count == CNT_FULL);
    pred_acc  = 1'b0;
    upd_acc   = 1'b0;
    drain     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = init_ptr;
    mem_wdata = 2'b01;
    case (state)
      ST_INIT: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (!bus.flush && init_ptr == IDX_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ready    = !full;
        pred_acc = bus.pred_valid && ready;
        upd_acc  = bus.upd_valid && ready;
        drain    = (count != '0) && (full || !pred_acc);
        if (drain) begin
          mem_we    = 1'b1;
          mem_addr  = q_idx[head];
          mem_wdata = sat_step(table_mem[q_idx[head]], q_act[head]);
        end
        if (bus.flush) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_ptr     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pred_out_vld <= 1'b0;
      pred_taken   <= 1'b0;
    end else begin
      init_ptr     <= (bus.flush || state == ST_RUN) ? '0 : init_ptr + IDX_W'(1);
      pred_out_vld <= pred_acc;
      if (pred_acc) pred_taken <= table_mem[bus.pred_idx][1];
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (upd_acc) tail <= next_ptr(tail);
        if (drain)   head <= next_ptr(head);
        count <= count + CNT_W'(upd_acc) - CNT_W'(drain);
      end
    end
  end

  // Storage without reset: the table is rewritten by the init walk, queue slots by enqueue.
  always_ff @(posedge clk) begin
    if (mem_we) table_mem[mem_addr] <= mem_wdata;
    if (upd_acc) begin
      q_idx[tail] <= bus.upd_idx;
      q_act[tail] <= bus.upd_actual;
    end
  end

  assign bus.pred_ready   = ready;
  assign bus.upd_ready    = ready;
  assign bus.busy         = busy;
  assign bus.pred_out_vld = pred_out_vld;
  assign bus.pred_taken   = pred_taken;

endmodule
